// File: rtl/messbauer_channel_sequencer.sv
// Mossbauer multichannel-scaling sequencer: sweep/channel timing and detector gating.
// Optional macro DEAD_TIME_EN adds a DEAD_CYCLES count-suppression window after each count.
module messbauer_channel_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int DEAD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sync_in,
    input  logic        det_in,
    input  logic [15:0] dwell,
    input  logic [11:0] n_chan,
    output logic        start,
    output logic        chanel,
    output logic        count,
    output logic [11:0] chan_idx,
    output logic [15:0] sweep_cnt,
    output logic        sync_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        RUN
    } state_t;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEAD_CYCLES < 1) begin : g_bad_cfg
        $error("messbauer_channel_sequencer: unsupported parameter value");
    end

    logic [SYNC_STAGES-1:0] det_sync_q;
    logic [SYNC_STAGES-1:0] sync_sync_q;
    logic                   det_prev_q;
    logic                   sync_prev_q;

    state_t      state_q;
    logic        rst_ok_q;
    logic        start_q;
    logic        chanel_q;
    logic        count_q;
    logic [11:0] idx_q;
    logic [15:0] sweep_q;
    logic        err_q;
    logic        busy_q;
    logic [15:0] dcnt_q;
    logic [15:0] dwell_lat_q;
    logic [11:0] nch_lat_q;

    logic        det_rise;
    logic        sync_rise;
    logic        det_ok;
    logic [15:0] dwell_eff;
    logic [11:0] nch_eff;

    assign det_rise  = det_sync_q[SYNC_STAGES-1] & ~det_prev_q;
    assign sync_rise = sync_sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    assign dwell_eff = (dwell == 16'd0) ? 16'd1 : dwell;
    assign nch_eff   = (n_chan == 12'd0) ? 12'd1 : n_chan;

`ifdef DEAD_TIME_EN
    logic [15:0] dead_q;
    assign det_ok = det_rise & (dead_q == 16'd0);
`else
    assign det_ok = det_rise;
`endif

    // Bring the asynchronous detector and sweep-sync pulses into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_sync_q  <= '0;
            sync_sync_q <= '0;
            det_prev_q  <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            det_sync_q  <= {det_sync_q[SYNC_STAGES-2:0], det_in};
            sync_sync_q <= {sync_sync_q[SYNC_STAGES-2:0], sync_in};
            det_prev_q  <= det_sync_q[SYNC_STAGES-1];
            sync_prev_q <= sync_sync_q[SYNC_STAGES-1];
        end
    end

    // Sweep FSM with registered pulse and status outputs; held one clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rst_ok_q    <= 1'b0;
            start_q     <= 1'b0;
            chanel_q    <= 1'b0;
            count_q     <= 1'b0;
            idx_q       <= '0;
            sweep_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            dcnt_q      <= '0;
            dwell_lat_q <= 16'd1;
            nch_lat_q   <= 12'd1;
`ifdef DEAD_TIME_EN
            dead_q      <= '0;
`endif
        end else begin
            rst_ok_q <= 1'b1;
            start_q  <= 1'b0;
            chanel_q <= 1'b0;
            count_q  <= 1'b0;
            if (rst_ok_q) begin
                if (!enable) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    dcnt_q  <= '0;
`ifdef DEAD_TIME_EN
                    dead_q  <= '0;
`endif
                end else begin
                    unique case (state_q)
                        IDLE: begin
                            state_q <= WAIT_SYNC;
                            busy_q  <= 1'b1;
                            sweep_q <= '0;
                            err_q   <= 1'b0;
                        end
                        WAIT_SYNC: begin
                            if (sync_rise) begin
                                state_q     <= RUN;
                                start_q     <= 1'b1;
                                idx_q       <= '0;
                                dcnt_q      <= dwell_eff;
                                dwell_lat_q <= dwell_eff;
                                nch_lat_q   <= nch_eff;
                            end
                        end
                        RUN: begin
                            count_q <= det_ok;
`ifdef DEAD_TIME_EN
                            if (det_ok)
                                dead_q <= 16'(DEAD_CYCLES);
                            else if (dead_q != 16'd0)
                                dead_q <= dead_q - 16'd1;
`endif
                            if (sync_rise) begin
                                err_q       <= 1'b1;
                                start_q     <= 1'b1;
                                idx_q       <= '0;
                                dcnt_q      <= dwell_eff;
                                dwell_lat_q <= dwell_eff;
                                nch_lat_q   <= nch_eff;
                            end else if (dcnt_q == 16'd1) begin
                                chanel_q <= 1'b1;
                                dcnt_q   <= dwell_lat_q;
                                if (idx_q == nch_lat_q - 12'd1) begin
                                    idx_q   <= '0;
                                    sweep_q <= sweep_q + 16'd1;
                                    state_q <= WAIT_SYNC;
`ifdef DEAD_TIME_EN
                                    dead_q  <= '0;
`endif
                                end else begin
                                    idx_q <= idx_q + 12'd1;
                                end
                            end else begin
                                dcnt_q <= dcnt_q - 16'd1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign start     = start_q;
    assign chanel    = chanel_q;
    assign count     = count_q;
    assign chan_idx  = idx_q;
    assign sweep_cnt = sweep_q;
    assign sync_err  = err_q;
    assign busy      = busy_q;

endmodule
